// File: rtl/nim_tac_pkg.sv
`default_nettype none
// ============================================================================
// Package : nim_tac_pkg
// Shared FSM state encoding and output-word field layout for the TAC readout.
// Rev     : 1.0
// ============================================================================
package nim_tac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } arb_state_t;

    localparam int CH_MSB   = 63;
    localparam int CH_LSB   = 60;
    localparam int SEQ_MSB  = 59;
    localparam int SEQ_LSB  = 52;
    localparam int DATA_MSB = 31;

    localparam int GRANT_W  = 4;
    localparam int SEQ_W    = 8;

endpackage : nim_tac_pkg
`default_nettype wire

// File: rtl/nim_tac_readout_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Combinational round-robin search: first requester strictly after 'last'.
// Rev    : 1.0
// ============================================================================
module rr_pick #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] req,
    input  logic [3:0]     last,
    output logic           found,
    output logic [3:0]     idx
);

    logic [15:0] req_ext;
    logic [4:0]  cand;

    assign req_ext = 16'(req);

    // Walk offsets 1..NCH so the last granted channel is considered only last.
    always_comb begin
        found = 1'b0;
        idx   = 4'd0;
        cand  = 5'd0;
        for (int i = 1; i <= NCH; i++) begin
            cand = {1'b0, last} + 5'(i);
            if (cand >= 5'(NCH)) begin
                cand = cand - 5'(NCH);
            end
            if (!found && req_ext[cand[3:0]]) begin
                found = 1'b1;
                idx   = cand[3:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/nim_tac_readout_arbiter.sv
`default_nettype none
// ============================================================================
// Module : nim_tac_readout_arbiter
// Round-robin readout of NCH TAC timing FIFOs onto one tagged 64-bit stream.
// Rev    : 1.0
// ============================================================================
module nim_tac_readout_arbiter
    import nim_tac_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NCH-1:0]    ch_empty,
    output logic [NCH-1:0]    ch_rd_en,
    input  logic [NCH*32-1:0] ch_dout,
    output logic [63:0]       b_data,
    output logic              b_data_we,
    input  logic              b_enable,
    output logic [3:0]        grant,
    output logic [31:0]       words_out
);

    arb_state_t             state_q, state_d;
    logic [GRANT_W-1:0]     grant_q, grant_d;
    logic [7:0]             burst_cnt_q, burst_cnt_d;
    logic [SEQ_W-1:0]       seq_q [NCH];
    logic [SEQ_W-1:0]       seq_d [NCH];
    logic [31:0]            words_q, words_d;
    logic [63:0]            b_data_q, b_data_d;

    logic                   pick_found;
    logic [3:0]             pick_idx;
    logic [SEQ_W-1:0]       sel_seq;
    logic [31:0]            sel_dout;
    logic                   sel_empty;
    logic [8:0]             burst_inc;

    rr_pick #(
        .NCH (NCH)
    ) u_rr_pick (
        .req   (~ch_empty),
        .last  (grant_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Per-channel views of the currently granted channel.
    always_comb begin
        sel_seq   = '0;
        sel_dout  = '0;
        sel_empty = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (grant_q == 4'(i)) begin
                sel_seq   = seq_q[i];
                sel_dout  = ch_dout[i*32 +: 32];
                sel_empty = ch_empty[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        seq_d       = seq_q;
        words_d     = words_q;
        b_data_d    = b_data_q;
        ch_rd_en    = '0;
        b_data_we   = 1'b0;
        burst_inc   = {1'b0, burst_cnt_q} + 9'd1;

        case (state_q)
            IDLE: begin
                if (enable && pick_found) begin
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = READ;
                end
            end
            READ: begin
                for (int i = 0; i < NCH; i++) begin
                    ch_rd_en[i] = (grant_q == 4'(i));
                end
                state_d = CAPTURE;
            end
            CAPTURE: begin
                b_data_d                   = '0;
                b_data_d[CH_MSB:CH_LSB]    = grant_q;
                b_data_d[SEQ_MSB:SEQ_LSB]  = sel_seq;
                b_data_d[DATA_MSB:0]       = sel_dout;
                state_d                    = SEND;
            end
            SEND: begin
                b_data_we = b_enable;
                if (b_enable) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (grant_q == 4'(i)) begin
                            seq_d[i] = sel_seq + 8'd1;
                        end
                    end
                    words_d     = words_q + 32'd1;
                    burst_cnt_d = burst_inc[7:0];
                    // Empty flag is settled here: the last pop was two cycles ago.
                    if (enable && (burst_inc < 9'(MAX_BURST)) && !sel_empty) begin
                        state_d = READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 4'(NCH - 1);
            burst_cnt_q <= '0;
            words_q     <= '0;
            b_data_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                seq_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            words_q     <= words_d;
            b_data_q    <= b_data_d;
            seq_q       <= seq_d;
        end
    end

    assign b_data    = b_data_q;
    assign grant     = grant_q;
    assign words_out = words_q;

endmodule : nim_tac_readout_arbiter
`default_nettype wire

// File: tb/tb_nim_tac_readout_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_nim_tac_readout_arbiter
// Directed bench with behavioural per-channel FIFOs (read latency 1).
// Rev    : 1.0
// ============================================================================
module tb_nim_tac_readout_arbiter;

    localparam int NCH       = 4;
    localparam int MAX_BURST = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              b_enable = 1'b0;
    logic [NCH-1:0]    ch_empty;
    logic [NCH-1:0]    ch_rd_en;
    logic [NCH*32-1:0] ch_dout = '0;
    logic [63:0]       b_data;
    logic              b_data_we;
    logic [3:0]        grant;
    logic [31:0]       words_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] fifo_mem [NCH][512];
    int          wp [NCH];
    int          rp [NCH];
    int          rd_cnt [NCH];
    int          underflow = 0;
    int          onehot_err = 0;
    logic [63:0] log_data [1024];
    int          log_n = 0;

    nim_tac_readout_arbiter #(
        .NCH       (NCH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .ch_empty  (ch_empty),
        .ch_rd_en  (ch_rd_en),
        .ch_dout   (ch_dout),
        .b_data    (b_data),
        .b_data_we (b_data_we),
        .b_enable  (b_enable),
        .grant     (grant),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < NCH; i++) begin
            wp[i] = 0;
            rp[i] = 0;
            rd_cnt[i] = 0;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_empty[i] = (wp[i] == rp[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (ch_rd_en[i] === 1'b1) begin
                if (rp[i] == wp[i]) underflow <= underflow + 1;
                ch_dout[i*32 +: 32] <= fifo_mem[i][rp[i] % 512];
                rp[i] <= rp[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (b_data_we === 1'b1) begin
            log_data[log_n % 1024] <= b_data;
            log_n <= log_n + 1;
        end
        if ($countones(ch_rd_en) > 1) onehot_err <= onehot_err + 1;
        for (int i = 0; i < NCH; i++) begin
            if (ch_rd_en[i] === 1'b1) rd_cnt[i] <= rd_cnt[i] + 1;
        end
    end

    task automatic push(input int ch, input logic [31:0] d);
        fifo_mem[ch][wp[ch] % 512] = d;
        wp[ch] = wp[ch] + 1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_words(input int target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (log_n >= target) break;
            sample();
        end
        if (log_n >= target) ok = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1; enable = 1'b0; b_enable = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk);
        sample();
        total++; if (b_data !== 64'd0) begin bad++; $display("FAIL reset_b_data: got %h want 0", b_data); end
        total++; if (b_data_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", b_data_we); end
        total++; if (ch_rd_en !== 4'd0) begin bad++; $display("FAIL reset_rd_en: got %b want 0000", ch_rd_en); end
        total++; if (grant !== 4'd3) begin bad++; $display("FAIL reset_grant: got %0d want 3", grant); end
        total++; if (words_out !== 32'd0) begin bad++; $display("FAIL reset_words: got %0d want 0", words_out); end
    endtask

    task automatic test_single_word();
        int r0;
        do_reset();
        r0 = rd_cnt[2];
        enable = 1'b1; b_enable = 1'b1;
        push(2, 32'h0000_1234);
        sample();
        total++; if (ch_rd_en !== 4'b0000) begin bad++; $display("FAIL single_c0_rd: got %b want 0000", ch_rd_en); end
        sample();
        total++; if (ch_rd_en !== 4'b0100) begin bad++; $display("FAIL single_c1_rd: got %b want 0100", ch_rd_en); end
        sample();
        total++; if (b_data_we !== 1'b0) begin bad++; $display("FAIL single_c2_we: got %b want 0", b_data_we); end
        sample();
        total++; if (b_data_we !== 1'b1) begin bad++; $display("FAIL single_c3_we: got %b want 1", b_data_we); end
        total++; if (b_data !== 64'h2000_0000_0000_1234) begin bad++; $display("FAIL single_data: got %h want 2000000000001234", b_data); end
        sample();
        total++; if (words_out !== 32'd1) begin bad++; $display("FAIL single_words: got %0d want 1", words_out); end
        total++; if (rd_cnt[2] - r0 !== 1) begin bad++; $display("FAIL single_rd_count: got %0d want 1", rd_cnt[2] - r0); end
        total++; if (grant !== 4'd2) begin bad++; $display("FAIL single_grant: got %0d want 2", grant); end
    endtask

    task automatic test_round_robin();
        int order [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
        int occ [4] = '{0, 0, 0, 0};
        int base;
        bit ok;
        logic [63:0] exp;
        do_reset();
        base = log_n;
        for (int ch = 0; ch < 4; ch++)
            for (int k = 0; k < 3; k++)
                push(ch, 32'hC0DE_0000 | 32'(ch << 8) | 32'(k));
        enable = 1'b1; b_enable = 1'b1;
        wait_words(base + 12, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_timeout: got %0d words want 12", log_n - base); end
        for (int j = 0; j < 12; j++) begin
            exp = {4'(order[j]), 8'(occ[order[j]]), 20'h0,
                   32'hC0DE_0000 | 32'(order[j] << 8) | 32'(occ[order[j]])};
            occ[order[j]]++;
            total++;
            if (log_data[base + j] !== exp) begin
                bad++; $display("FAIL rr_word%0d: got %h want %h", j, log_data[base + j], exp);
            end
        end
    endtask

    task automatic test_back_to_back_backpressure();
        int base, r0, err;
        bit ok;
        do_reset();
        base = log_n; r0 = rd_cnt[1]; err = 0;
        enable = 1'b1;
        push(1, 32'hAAAA_0001);
        push(1, 32'hAAAA_0002);
        repeat (3) @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            sample();
            if (b_data !== 64'h1000_0000_AAAA_0001 || b_data_we !== 1'b0) err++;
        end
        total++; if (err != 0) begin bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", err); end
        total++; if (rd_cnt[1] - r0 !== 1) begin bad++; $display("FAIL bp_rd_count: got %0d want 1", rd_cnt[1] - r0); end
        @(posedge clk); #2;
        b_enable = 1'b1;
        sample();
        total++; if (b_data_we !== 1'b1) begin bad++; $display("FAIL bp_release_we: got %b want 1", b_data_we); end
        wait_words(base + 2, 30, ok);
        repeat (5) sample();
        total++; if (log_n - base !== 2) begin bad++; $display("FAIL bp_word_count: got %0d want 2", log_n - base); end
        total++; if (log_data[base] !== 64'h1000_0000_AAAA_0001) begin bad++; $display("FAIL bp_word0: got %h want 10000000aaaa0001", log_data[base]); end
        total++; if (log_data[base + 1] !== 64'h1010_0000_AAAA_0002) begin bad++; $display("FAIL bp_word1: got %h want 10100000aaaa0002", log_data[base + 1]); end
        total++; if (words_out !== 32'd2) begin bad++; $display("FAIL bp_words: got %0d want 2", words_out); end
    endtask

    task automatic test_seq_wrap();
        int base;
        bit ok;
        logic [63:0] exp;
        do_reset();
        base = log_n;
        for (int k = 0; k < 257; k++) push(1, 32'h5100_0000 | 32'(k));
        enable = 1'b1; b_enable = 1'b1;
        wait_words(base + 257, 2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got %0d words want 257", log_n - base); end
        for (int k = 0; k < 257; k++) begin
            exp = {4'd1, 8'(k), 20'h0, 32'h5100_0000 | 32'(k)};
            total++;
            if (log_data[base + k] !== exp) begin
                bad++; $display("FAIL wrap_word%0d: got %h want %h", k, log_data[base + k], exp);
            end
        end
        repeat (3) sample();
        total++; if (words_out !== 32'd257) begin bad++; $display("FAIL wrap_words: got %0d want 257", words_out); end
    endtask

    task automatic test_enable_drop();
        int base, r0;
        bit ok;
        logic [63:0] exp;
        do_reset();
        base = log_n; r0 = rd_cnt[0];
        enable = 1'b1; b_enable = 1'b1;
        for (int k = 0; k < 3; k++) push(0, 32'hE000_0000 | 32'(k));
        @(posedge clk); #2;
        enable = 1'b0;
        repeat (12) sample();
        total++; if (log_n - base !== 1) begin bad++; $display("FAIL drop_words: got %0d want 1", log_n - base); end
        total++; if (rd_cnt[0] - r0 !== 1) begin bad++; $display("FAIL drop_rd_count: got %0d want 1", rd_cnt[0] - r0); end
        total++; if (ch_rd_en !== 4'd0 || b_data_we !== 1'b0) begin bad++; $display("FAIL drop_idle: got rd=%b we=%b want 0000/0", ch_rd_en, b_data_we); end
        @(posedge clk); #2;
        enable = 1'b1;
        wait_words(base + 3, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_resume: got %0d words want 3", log_n - base); end
        for (int k = 0; k < 3; k++) begin
            exp = {4'd0, 8'(k), 20'h0, 32'hE000_0000 | 32'(k)};
            total++;
            if (log_data[base + k] !== exp) begin
                bad++; $display("FAIL drop_word%0d: got %h want %h", k, log_data[base + k], exp);
            end
        end
    endtask

    task automatic test_reset_in_capture();
        int base, r0;
        bit ok;
        do_reset();
        enable = 1'b1; b_enable = 1'b1;
        base = log_n;
        push(2, 32'h0000_0A01);
        wait_words(base + 1, 20, ok);
        @(posedge clk); #2;
        r0 = rd_cnt[2];
        push(2, 32'h0000_0A02);
        push(2, 32'h0000_0A03);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk);
        sample();
        total++; if (b_data !== 64'd0 || b_data_we !== 1'b0 || ch_rd_en !== 4'd0) begin bad++; $display("FAIL rstcap_outputs: got data=%h we=%b rd=%b want 0/0/0000", b_data, b_data_we, ch_rd_en); end
        total++; if (grant !== 4'd3 || words_out !== 32'd0) begin bad++; $display("FAIL rstcap_state: got grant=%0d words=%0d want 3/0", grant, words_out); end
        total++; if (rd_cnt[2] - r0 !== 1) begin bad++; $display("FAIL rstcap_popped: got %0d want 1", rd_cnt[2] - r0); end
        @(posedge clk); #2;
        reset = 1'b0;
        push(0, 32'h0000_0B01);
        base = log_n;
        wait_words(base + 2, 30, ok);
        total++; if (log_data[base] !== 64'h0000_0000_0000_0B01) begin bad++; $display("FAIL rstcap_first: got %h want 0000000000000b01", log_data[base]); end
        total++; if (log_data[base + 1] !== 64'h2000_0000_0000_0A03) begin bad++; $display("FAIL rstcap_second: got %h want 2000000000000a03", log_data[base + 1]); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_round_robin();
        test_back_to_back_backpressure();
        test_seq_wrap();
        test_enable_drop();
        test_reset_in_capture();
        repeat (3) sample();
        total++; if (underflow != 0) begin bad++; $display("FAIL empty_read: got %0d want 0", underflow); end
        total++; if (onehot_err != 0) begin bad++; $display("FAIL rd_onehot: got %0d want 0", onehot_err); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_nim_tac_readout_arbiter
`default_nettype wire
